amp_ctrl_mc: RTL
================

# amp_ctrl_mc

Parametrised multi-amplifier state controller, successor to the single-amp state control inside the amplifier interface. It gates N_AMP class-D amplifiers through power-up, I2C configuration, soft-unmute gain ramp, run, soft-mute, and latched fault. It sits between the S/PDIF lock detector, the shared amp I2C master (request/ack handshake) and the amp enable/mute pins. The gain output scales I2S samples downstream.

## Interface
- N_AMP, 2: number of amplifiers controlled (1..8).
- LOCK_CYCLES, 1024: consecutive locked cycles required before power-up.
- ENABLE_DLY, 256: cycles from nenable low to first config request.
- RAMP_W, 8: gain width; full scale = 2^RAMP_W-1.
- STEP_CYC, 16: cycles per gain step (≥1).
- RETRY_MAX, 3: config attempts per amp before fault.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  block enable; low forces shutdown.
- audio_locked_in  in  1  S/PDIF decoder lock.
- nerror_in  in  N_AMP  per-amp fault pin, active low.
- fault_clr_in  in  1  one-cycle pulse; clears latched faults.
- cfg_req_out  out  1  config request to I2C master.
- cfg_idx_out  out  $clog2(N_AMP) (min 1)  amp index being configured.
- cfg_done_in  in  1  one-cycle pulse, transaction OK.
- cfg_err_in  in  1  one-cycle pulse, transaction NACK/fail.
- nenable_out  out  N_AMP  amp enable, active low.
- nmute_out  out  N_AMP  amp mute, active low (1 = unmuted).
- gain_out  out  RAMP_W  soft-mute gain.
- fault_out  out  N_AMP  latched fault per amp.
- state_out  out  3  current state encoding.

## Operation
- States (encoding): OFF 0, WAIT_LOCK 1, ENABLE 2, CONFIG 3, UNMUTE 4, RUN 5, RAMP_DOWN 6, FAULT 7.
- Reset: state OFF, nenable_out all 1, nmute_out all 0, gain_out 0, cfg_req_out 0, cfg_idx_out 0, fault_out 0, all counters 0.
- OFF: if ena → WAIT_LOCK.
- WAIT_LOCK: lock counter increments while audio_locked_in=1; clears to 0 on any 0. At LOCK_CYCLES consecutive highs → ENABLE.
- ENABLE: nenable_out all 0; after ENABLE_DLY cycles → CONFIG with idx=0, retry=0.
- CONFIG: cfg_req_out=1 with cfg_idx_out stable until cfg_done_in or cfg_err_in. On done: req drops for one cycle. Then idx+1 and retry=0; after idx N_AMP-1 → UNMUTE. On err: retry+1, req drops one cycle and reasserts. At RETRY_MAX failures: set fault_out[idx] → FAULT. done and err in the same cycle count as err. Pulses arriving while req=0 are ignored.
- UNMUTE: nmute_out all 1 on entry; gain_out +1 every STEP_CYC cycles; at full scale → RUN.
- RUN: gain at full scale. Any nerror_in[i]=0 latches fault_out[i], then → RAMP_DOWN. audio_locked_in=0 (no debounce) → RAMP_DOWN.
- RAMP_DOWN: gain_out −1 every STEP_CYC cycles. At 0: nmute_out all 0. Next state is FAULT if any fault_out bit is set, else OFF (nenable_out all 1).
- FAULT: nenable_out all 1, nmute_out all 0, gain_out 0, cfg_req_out 0. fault_clr_in clears fault_out → OFF.
- ena=0: from UNMUTE/RUN → RAMP_DOWN; from WAIT_LOCK/ENABLE/CONFIG → OFF (req dropped, nenable all 1). FAULT holds regardless of ena.
- Lock loss during ENABLE/CONFIG → OFF. Lock loss during UNMUTE → RAMP_DOWN from the current gain.
- nerror_in is sampled only in UNMUTE/RUN/RAMP_DOWN; faults latch in any of those states.

## Timing
- All outputs registered; state_out changes on the edge after the triggering condition is sampled.
- WAIT_LOCK→ENABLE: on the edge where the LOCK_CYCLES-th consecutive high sample is seen.
- nenable_out falls on the ENABLE entry edge. cfg_req_out rises ENABLE_DLY cycles later.
- cfg_req_out falls on the edge after the cfg_done_in/cfg_err_in sample and is low for exactly 1 cycle between requests.
- Full ramp up or down: (2^RAMP_W−1)·STEP_CYC cycles. Gain never wraps; saturates at 0 and full scale.
- Reset mid-operation: all outputs return to reset values on the next edge.

## Test plan
- N_AMP=2, LOCK_CYCLES=8, ENABLE_DLY=4, RAMP_W=4, STEP_CYC=2, RETRY_MAX=2 for all scenarios.
- Lock held high, both configs acked → nenable 2'b00 at cycle 9, two requests idx 0/1, gain steps 0→15 over 30 cycles, state 5.
- Lock toggles low at count 7 → counter restarts; ENABLE only after 8 further consecutive highs.
- Amp 1 errs twice → fault_out=2'b10, state 7, nenable 2'b11. fault_clr_in → state 0.
- In RUN, nerror_in[0]=0 → gain 15→0 over 30 cycles, nmute 2'b00, fault_out=2'b01, state 7.
- ena=0 in RUN → ramp to 0, state 0, nenable 2'b11. Reset during UNMUTE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/amp_ctrl_mc.sv
// amp_ctrl_mc: sequences N_AMP class-D amplifiers through lock wait, power-up,
// I2C configuration (with retries), soft-unmute gain ramp, run, soft-mute and
// latched fault. All outputs are registered and derived from the next state.
module amp_ctrl_mc #(
    parameter int  N_AMP       = 2,
    parameter int  LOCK_CYCLES = 1024,
    parameter int  ENABLE_DLY  = 256,
    parameter int  RAMP_W      = 8,
    parameter int  STEP_CYC    = 16,
    parameter int  RETRY_MAX   = 3,
    localparam int IDX_W       = (N_AMP > 1) ? $clog2(N_AMP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena,
    input  logic              audio_locked_in,
    input  logic [N_AMP-1:0]  nerror_in,
    input  logic              fault_clr_in,
    output logic              cfg_req_out,
    output logic [IDX_W-1:0]  cfg_idx_out,
    input  logic              cfg_done_in,
    input  logic              cfg_err_in,
    output logic [N_AMP-1:0]  nenable_out,
    output logic [N_AMP-1:0]  nmute_out,
    output logic [RAMP_W-1:0] gain_out,
    output logic [N_AMP-1:0]  fault_out,
    output logic [2:0]        state_out
);
    // One shared cycle counter serves lock debounce, enable delay and gain steps.
    localparam int CNT_MAX0 = (LOCK_CYCLES > ENABLE_DLY) ? LOCK_CYCLES : ENABLE_DLY;
    localparam int CNT_MAX  = (CNT_MAX0 > STEP_CYC) ? CNT_MAX0 : STEP_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int RETRY_W  = $clog2(RETRY_MAX + 1);

    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DLY_LAST   = CNT_W'(ENABLE_DLY - 1);
    localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);
    localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_AMP - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [RAMP_W-1:0]  GAIN_FS    = '1;
    localparam logic [RAMP_W-1:0]  GAIN_ONE   = RAMP_W'(1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_ENABLE    = 3'd2,
        S_CONFIG    = 3'd3,
        S_UNMUTE    = 3'd4,
        S_RUN       = 3'd5,
        S_RAMP_DOWN = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RAMP_W-1:0]  gain_q, gain_d;
    logic [N_AMP-1:0]   fault_q, fault_d;
    logic               req_q, req_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [N_AMP-1:0]   nenable_q, nenable_d;
    logic [N_AMP-1:0]   nmute_q, nmute_d;

    logic               sample_err;
    logic               ramp_done;
    logic [N_AMP-1:0]   new_fault;
    logic [N_AMP-1:0]   cfg_sel;

    // Amp fault pins only matter while the amps are unmuted or ramping.
    assign sample_err = (state_q == S_UNMUTE) || (state_q == S_RUN) || (state_q == S_RAMP_DOWN);

    generate
        for (genvar gi = 0; gi < N_AMP; gi++) begin : g_amp
            assign new_fault[gi] = sample_err & ~nerror_in[gi];
            assign cfg_sel[gi]   = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gain_d    = gain_q;
        fault_d   = fault_q | new_fault;
        req_d     = 1'b0;
        idx_d     = idx_q;
        retry_d   = retry_q;
        ramp_done = 1'b0;
        case (state_q)
            S_OFF: begin
                cnt_d   = '0;
                gain_d  = '0;
                idx_d   = '0;
                retry_d = '0;
                if (ena) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (!ena) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (!audio_locked_in) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = S_ENABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ENABLE: begin
                if (!ena || !audio_locked_in) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DLY_LAST) begin
                    state_d = S_CONFIG;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_CONFIG: begin
                if (!ena || !audio_locked_in) begin
                    state_d = S_OFF;
                    idx_d   = '0;
                    retry_d = '0;
                end else if (!req_q) begin
                    // One-cycle gap elapsed; responses seen during it are ignored.
                    req_d = 1'b1;
                end else if (cfg_err_in) begin
                    if (retry_q == RETRY_LAST) begin
                        fault_d = fault_q | cfg_sel;
                        state_d = S_FAULT;
                    end else begin
                        retry_d = retry_q + RETRY_ONE;
                    end
                end else if (cfg_done_in) begin
                    retry_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_UNMUTE;
                        cnt_d   = '0;
                        gain_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    req_d = 1'b1;
                end
            end
            S_UNMUTE: begin
                if (!ena || !audio_locked_in || (|new_fault)) begin
                    state_d = S_RAMP_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d  = '0;
                    gain_d = gain_q + GAIN_ONE;
                    if (gain_q == GAIN_FS - GAIN_ONE) state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                gain_d = GAIN_FS;
                if (!ena || !audio_locked_in || (|new_fault)) begin
                    state_d = S_RAMP_DOWN;
                    cnt_d   = '0;
                end
            end
            S_RAMP_DOWN: begin
                if (gain_q == '0) begin
                    ramp_done = 1'b1;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d     = '0;
                    gain_d    = gain_q - GAIN_ONE;
                    ramp_done = (gain_q == GAIN_ONE);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (ramp_done) begin
                    state_d = (|fault_d) ? S_FAULT : S_OFF;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                cnt_d  = '0;
                gain_d = '0;
                if (fault_clr_in) begin
                    fault_d = '0;
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Pin levels follow the state being entered so they change on the entry edge.
        nenable_d = '1;
        nmute_d   = '0;
        if ((state_d == S_ENABLE) || (state_d == S_CONFIG) || (state_d == S_UNMUTE) ||
            (state_d == S_RUN) || (state_d == S_RAMP_DOWN)) begin
            nenable_d = '0;
        end
        if ((state_d == S_UNMUTE) || (state_d == S_RUN) || (state_d == S_RAMP_DOWN)) begin
            nmute_d = '1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            gain_q    <= '0;
            fault_q   <= '0;
            req_q     <= 1'b0;
            idx_q     <= '0;
            retry_q   <= '0;
            nenable_q <= '1;
            nmute_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gain_q    <= gain_d;
            fault_q   <= fault_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            nenable_q <= nenable_d;
            nmute_q   <= nmute_d;
        end
    end

    assign cfg_req_out = req_q;
    assign cfg_idx_out = idx_q;
    assign nenable_out = nenable_q;
    assign nmute_out   = nmute_q;
    assign gain_out    = gain_q;
    assign fault_out   = fault_q;
    assign state_out   = state_q;

endmodule
